// File: rtl/multi_line_buffer_pkg.sv
// multi_line_buffer_pkg: buffer states, ring limits and pointer helper.
// CLEARING is only reachable when MULTI_LINE_BUFFER_CLEAR_EN is defined.
package multi_line_buffer_pkg;

    localparam int MAX_BUFS = 4;
    localparam int PTR_W    = 2;

    typedef logic [PTR_W-1:0] ptr_t;

    typedef enum logic [2:0] {
        FREE,
        RENDERING,
        FILLED,
        DISPLAYING,
        CLEARING
    } buf_state_t;

    function automatic ptr_t next_ptr(input ptr_t ptr, input int num_bufs);
        if (int'(ptr) >= num_bufs - 1) return '0;
        return ptr + ptr_t'(1);
    endfunction

endpackage

// File: rtl/multi_line_buffer_if.sv
// multi_line_buffer_if: renderer write side, composer read side and status.
// master drives stimulus, slave is the line buffer itself.
interface multi_line_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int IDX_WIDTH  = 10
);
    logic [IDX_WIDTH-1:0]  renderer_wr_idx;
    logic [DATA_WIDTH-1:0] renderer_wr_data;
    logic                  renderer_wr_en;
    logic                  render_done;
    logic                  render_buf_avail;
    logic                  line_start;
    logic [IDX_WIDTH-1:0]  composer_rd_idx;
    logic [DATA_WIDTH-1:0] composer_rd_data;
    logic [2:0]            filled_count;
    logic                  underrun;
    logic                  proto_err;

    modport master (
        output renderer_wr_idx, renderer_wr_data, renderer_wr_en,
        output render_done, line_start, composer_rd_idx,
        input  render_buf_avail, composer_rd_data, filled_count,
        input  underrun, proto_err
    );

    modport slave (
        input  renderer_wr_idx, renderer_wr_data, renderer_wr_en,
        input  render_done, line_start, composer_rd_idx,
        output render_buf_avail, composer_rd_data, filled_count,
        output underrun, proto_err
    );
endinterface

// File: rtl/line_buf_ram.sv
// line_buf_ram: single-clock 1R1W line RAM with registered read.
// Out-of-range addresses neither write nor update the read register.
module line_buf_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int IDX_WIDTH  = 10,
    parameter int DEPTH      = 640
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_WIDTH-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [IDX_WIDTH-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    localparam logic [IDX_WIDTH:0] DEPTH_W = (IDX_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && ({1'b0, wr_addr} < DEPTH_W))
            mem[wr_addr] <= wr_data;
        if ({1'b0, rd_addr} < DEPTH_W)
            rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/multi_line_buffer.sv
// multi_line_buffer: ring of NUM_BUFS line RAMs between renderer and composer.
// Define MULTI_LINE_BUFFER_CLEAR_EN to wipe released buffers to CLEAR_VALUE.
module multi_line_buffer
    import multi_line_buffer_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int IDX_WIDTH   = 10,
    parameter int LINE_PIXELS = 640,
    parameter int NUM_BUFS    = 2,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input logic clk,
    input logic rst_n,
    multi_line_buffer_if.slave bus
);
    localparam logic [IDX_WIDTH:0]   LINE_W   = (IDX_WIDTH + 1)'(LINE_PIXELS);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(LINE_PIXELS - 1);
    localparam ptr_t                 LAST_PTR = ptr_t'(NUM_BUFS - 1);
`ifdef MULTI_LINE_BUFFER_CLEAR_EN
    localparam buf_state_t RELEASED = CLEARING;
`else
    localparam buf_state_t RELEASED = FREE;
`endif

    buf_state_t st   [MAX_BUFS];
    buf_state_t st_n [MAX_BUFS];

    ptr_t wr_ptr, wr_ptr_n, wr_nx;
    ptr_t rd_ptr, rd_ptr_n, rd_nx;
    logic display_valid, dv_n;
    logic avail, avail_n;
    logic underrun_q, underrun_n;
    logic proto_q, proto_n;
    logic [2:0] filled_q, filled_n;

    logic done_ok, ls_take, wr_ok, rd_in_range;

    ptr_t sel_ptr;
    logic sel_valid, sel_in;
    logic [DATA_WIDTH-1:0] ram_q [MAX_BUFS];

`ifdef MULTI_LINE_BUFFER_CLEAR_EN
    localparam logic [IDX_WIDTH-1:0] ONE = 1;
    logic [IDX_WIDTH-1:0] clr_cnt [MAX_BUFS];
`endif

    assign wr_nx   = next_ptr(wr_ptr, NUM_BUFS);
    assign rd_nx   = next_ptr(rd_ptr, NUM_BUFS);
    assign done_ok = bus.render_done & avail;
    assign wr_ok   = bus.renderer_wr_en & avail &
                     ({1'b0, bus.renderer_wr_idx} < LINE_W);
    assign rd_in_range = {1'b0, bus.composer_rd_idx} < LINE_W;

    // A buffer filled this very cycle is already eligible for display.
    assign ls_take = bus.line_start &
                     ((st[rd_nx] == FILLED) | (done_ok & (wr_ptr == rd_nx)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_BUFS; i++)
                st[i] <= (i == 0) ? RENDERING : FREE;
            wr_ptr        <= '0;
            rd_ptr        <= LAST_PTR;
            display_valid <= 1'b0;
            avail         <= 1'b1;
            underrun_q    <= 1'b0;
            proto_q       <= 1'b0;
            filled_q      <= '0;
            sel_ptr       <= '0;
            sel_valid     <= 1'b0;
            sel_in        <= 1'b0;
        end else begin
            for (int i = 0; i < MAX_BUFS; i++)
                st[i] <= st_n[i];
            wr_ptr        <= wr_ptr_n;
            rd_ptr        <= rd_ptr_n;
            display_valid <= dv_n;
            avail         <= avail_n;
            underrun_q    <= underrun_n;
            proto_q       <= proto_n;
            filled_q      <= filled_n;
            sel_ptr       <= rd_ptr;
            sel_valid     <= display_valid;
            sel_in        <= rd_in_range;
        end
    end

    always_comb begin
        for (int i = 0; i < MAX_BUFS; i++)
            st_n[i] = st[i];
        wr_ptr_n   = wr_ptr;
        rd_ptr_n   = rd_ptr;
        dv_n       = display_valid;
        avail_n    = avail;
        proto_n    = proto_q | (bus.render_done & ~avail);
        underrun_n = bus.line_start & ~ls_take;
`ifdef MULTI_LINE_BUFFER_CLEAR_EN
        for (int i = 0; i < MAX_BUFS; i++)
            if (st[i] == CLEARING && clr_cnt[i] == LAST_IDX)
                st_n[i] = FREE;
`endif
        if (done_ok)
            st_n[wr_ptr] = FILLED;
        if (ls_take) begin
            if (st[rd_ptr] == DISPLAYING)
                st_n[rd_ptr] = RELEASED;
            st_n[rd_nx] = DISPLAYING;
            rd_ptr_n    = rd_nx;
            dv_n        = 1'b1;
        end
        // The slot at rd_ptr is reserved even when FREE, capping FILLED at NUM_BUFS-1.
        if (done_ok) begin
            wr_ptr_n = wr_nx;
            if (st_n[wr_nx] == FREE && st[wr_nx] != CLEARING &&
                wr_nx != rd_ptr_n) begin
                st_n[wr_nx] = RENDERING;
                avail_n     = 1'b1;
            end else begin
                avail_n = 1'b0;
            end
        end else if (!avail && st[wr_ptr] == FREE && wr_ptr != rd_ptr_n) begin
            st_n[wr_ptr] = RENDERING;
            avail_n      = 1'b1;
        end
        filled_n = '0;
        for (int i = 0; i < NUM_BUFS; i++)
            filled_n = filled_n + 3'(st_n[i] == FILLED);
    end

    always_comb begin
        bus.composer_rd_data = (sel_valid && sel_in) ? ram_q[sel_ptr]
                                                     : CLEAR_VALUE;
    end

    assign bus.render_buf_avail = avail;
    assign bus.filled_count     = filled_q;
    assign bus.underrun         = underrun_q;
    assign bus.proto_err        = proto_q;

`ifdef MULTI_LINE_BUFFER_CLEAR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_BUFS; i++)
                clr_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < MAX_BUFS; i++)
                clr_cnt[i] <= (st[i] == CLEARING && clr_cnt[i] != LAST_IDX)
                              ? clr_cnt[i] + ONE : '0;
        end
    end
`endif

    for (genvar g = 0; g < MAX_BUFS; g++) begin : g_buf
        if (g < NUM_BUFS) begin : g_ram
            logic                  we;
            logic [IDX_WIDTH-1:0]  waddr;
            logic [DATA_WIDTH-1:0] wdata;

            always_comb begin
                we    = wr_ok && (wr_ptr == ptr_t'(g));
                waddr = bus.renderer_wr_idx;
                wdata = bus.renderer_wr_data;
`ifdef MULTI_LINE_BUFFER_CLEAR_EN
                if (st[g] == CLEARING) begin
                    we    = 1'b1;
                    waddr = clr_cnt[g];
                    wdata = CLEAR_VALUE;
                end
`endif
            end

            line_buf_ram #(
                .DATA_WIDTH (DATA_WIDTH),
                .IDX_WIDTH  (IDX_WIDTH),
                .DEPTH      (LINE_PIXELS)
            ) u_ram (
                .clk     (clk),
                .we      (we),
                .wr_addr (waddr),
                .wr_data (wdata),
                .rd_addr (bus.composer_rd_idx),
                .rd_data (ram_q[g])
            );
        end else begin : g_none
            assign ram_q[g] = '0;
        end
    end

endmodule

// File: tb/tb_multi_line_buffer.sv
// tb_multi_line_buffer: directed checks on a 2-deep and a 3-deep ring.
// Build with MULTI_LINE_BUFFER_CLEAR_EN to exercise the clear-on-release path.
module tb_multi_line_buffer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;
    int   n_wait;

    always #5 clk = ~clk;

    multi_line_buffer_if #(.DATA_WIDTH(8), .IDX_WIDTH(10)) b2 ();
    multi_line_buffer_if #(.DATA_WIDTH(8), .IDX_WIDTH(10)) b3 ();

    multi_line_buffer #(.NUM_BUFS(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2)
    );

    multi_line_buffer #(.NUM_BUFS(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b3)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr2(input int idx, input logic [7:0] d);
        b2.renderer_wr_en   = 1'b1;
        b2.renderer_wr_idx  = 10'(idx);
        b2.renderer_wr_data = d;
        tick();
        b2.renderer_wr_en   = 1'b0;
    endtask

    task automatic pulse2(input logic done, input logic ls);
        b2.render_done = done;
        b2.line_start  = ls;
        tick();
        b2.render_done = 1'b0;
        b2.line_start  = 1'b0;
    endtask

    task automatic rd2(input string tag, input int idx, input logic [7:0] exp);
        b2.composer_rd_idx = 10'(idx);
        tick();
        chk(tag, b2.composer_rd_data, exp);
    endtask

    task automatic wait_avail2(output int n);
        n = 0;
        while (!b2.render_buf_avail && n < 1000) begin
            tick();
            n++;
        end
    endtask

    initial begin
        b2.renderer_wr_idx = '0; b2.renderer_wr_data = '0;
        b2.renderer_wr_en  = 0;  b2.render_done = 0;
        b2.line_start = 0;       b2.composer_rd_idx = '0;
        b3.renderer_wr_idx = '0; b3.renderer_wr_data = '0;
        b3.renderer_wr_en  = 0;  b3.render_done = 0;
        b3.line_start = 0;       b3.composer_rd_idx = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        chk("rst_avail", b2.render_buf_avail, 1);
        chk("rst_data", b2.composer_rd_data, 8'h00);
        chk("rst_filled", b2.filled_count, 0);
        chk("rst_underrun", b2.underrun, 0);
        chk("rst_proto", b2.proto_err, 0);

        // 3-deep ring: two fills stall the renderer, third is a protocol error
        b3.render_done = 1; tick(); b3.render_done = 0; tick();
        chk("nb3_fill1", b3.filled_count, 1);
        chk("nb3_avail1", b3.render_buf_avail, 1);
        b3.render_done = 1; tick(); b3.render_done = 0;
        chk("nb3_fill2", b3.filled_count, 2);
        chk("nb3_avail2", b3.render_buf_avail, 0);
        b3.render_done = 1; tick(); b3.render_done = 0;
        chk("nb3_proto", b3.proto_err, 1);
        chk("nb3_fill2b", b3.filled_count, 2);
        b3.line_start = 1; tick(); b3.line_start = 0; tick();
        chk("nb3_avail_back", b3.render_buf_avail, 1);
        chk("nb3_fill_ls", b3.filled_count, 1);

        // 2-deep ping-pong
        rd2("pre_fill_rd5", 5, 8'h00);
        for (int i = 0; i < 640; i++) wr2(i, 8'(i));
        wr2(700, 8'hFF);
        pulse2(1, 0);
        chk("pp_filled1", b2.filled_count, 1);
        b2.composer_rd_idx = 10'd5;
        pulse2(0, 1);
        chk("pp_inflight", b2.composer_rd_data, 8'h00);
        chk("pp_avail", b2.render_buf_avail, 1);
        chk("pp_filled0", b2.filled_count, 0);
        chk("pp_no_ur", b2.underrun, 0);
        rd2("pp_rd5", 5, 8'h05);
        rd2("pp_rd639", 639, 8'h7F);
        rd2("range_rd700", 700, 8'h00);
        rd2("range_rd188", 188, 8'hBC);

        pulse2(0, 1);
        chk("ur_pulse", b2.underrun, 1);
        tick();
        chk("ur_clear", b2.underrun, 0);
        rd2("ur_repeat_rd5", 5, 8'h05);

`ifndef MULTI_LINE_BUFFER_CLEAR_EN
        wr2(5, 8'h55);
        wr2(6, 8'h66);
        pulse2(1, 1);
        chk("sim_avail", b2.render_buf_avail, 1);
        chk("sim_filled", b2.filled_count, 0);
        chk("sim_no_ur", b2.underrun, 0);
        rd2("sim_rd5", 5, 8'h55);
        rd2("sim_rd6", 6, 8'h66);
        wr2(5, 8'h99);
        pulse2(1, 1);
        chk("sim2_avail", b2.render_buf_avail, 1);
        rd2("sim2_rd5", 5, 8'h99);
        rd2("sim2_rd6", 6, 8'h06);
        rd2("pre_rst_rd5", 5, 8'h99);
`else
        for (int i = 0; i < 640; i++) wr2(i, 8'hAA);
        pulse2(1, 0);
        pulse2(0, 1);
        chk("clr_a_stall", b2.render_buf_avail, 0);
        wait_avail2(n_wait);
        chk("clr_a_cycles", n_wait, 641);
        rd2("clr_disp_rd1", 1, 8'hAA);
        wr2(0, 8'h22);
        pulse2(1, 0);
        pulse2(0, 1);
        wait_avail2(n_wait);
        chk("clr_aa_cycles", n_wait, 641);
        rd2("clr_a_rd1", 1, 8'h00);
        rd2("clr_a_rd0", 0, 8'h22);
        wr2(0, 8'h33);
        pulse2(1, 0);
        pulse2(0, 1);
        rd2("clr_aa_rd1", 1, 8'h00);
        rd2("clr_aa_rd2", 2, 8'h00);
        rd2("pre_rst_rd0", 0, 8'h33);
`endif
        chk("no_proto2", b2.proto_err, 0);

        // asynchronous reset in the middle of a line
        b2.renderer_wr_en  = 1'b1;
        b2.renderer_wr_idx = 10'd10;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_avail", b2.render_buf_avail, 1);
        chk("arst_data", b2.composer_rd_data, 8'h00);
        chk("arst_filled", b2.filled_count, 0);
        chk("arst_nb3_proto", b3.proto_err, 0);
        chk("arst_nb3_filled", b3.filled_count, 0);
        b2.renderer_wr_en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        rd2("post_rst_rd5", 5, 8'h00);
        chk("post_rst_underrun", b2.underrun, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
